// File: rtl/counter_down_pkg.sv
// Shared types for the loadable down-counter/timer.
// Holds the FSM state enum and its width.
package counter_down_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_down_prescaler.sv
// Tick prescaler: one tick every PRESCALE enabled clocks.
// Ports: clk, rst (sync, high), clr, en, tick.
`ifdef COUNTER_DOWN_PRESCALE_EN
module counter_down_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // A cleared cycle never ticks.
  assign tick = en && !clr && (cnt == LAST);

endmodule
`endif

// File: rtl/counter_down_load.sv
// Loadable down-counter/timer, one-shot or periodic.
// Ports: clk, rst, load, data, start, stop, auto_reload -> count, tc, busy.
// Macro COUNTER_DOWN_PRESCALE_EN: tick every PRESCALE clocks.
module counter_down_load
  import counter_down_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             tick;

`ifdef COUNTER_DOWN_PRESCALE_EN
  counter_down_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load | start | stop),
    .en  (state == RUN),
    .tick(tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      count_n  = data;
      reload_n = data;
      state_n  = start ? RUN : IDLE;
    end else if (stop) begin
      if (state == RUN) state_n = IDLE;
    end else if (start && state != RUN) begin
      case (state)
        IDLE: begin
          // Nothing left to count: finish at once.
          if (count == '0) begin
            state_n = DONE;
            tc_n    = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
        DONE: begin
          count_n = reload_reg;
          state_n = RUN;
        end
        default: ;
      endcase
    end else if (state == RUN && tick) begin
      // count of 0 in RUN only arises with a
      // zero reload; treat it as terminal too.
      if (count > WIDTH'(1)) begin
        count_n = count - 1'b1;
      end else begin
        tc_n = 1'b1;
        if (auto_reload) begin
          count_n = reload_reg;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
      busy       <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench for counter_down_load.
// Vector table, hand sequences and random vs model.
module tb_counter_down_load;

`ifdef COUNTER_DOWN_PRESCALE_EN
  localparam int TP = 4;
`else
  localparam int TP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, load, start, stop, auto_reload;
  logic [7:0] data;
  logic [7:0] count;
  logic       tc, busy;

  int checks = 0;
  int errors = 0;

  int m_count, m_reload, m_phase;
  bit m_run, m_done, m_tc;

  counter_down_load #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .start(start), .stop(stop),
    .auto_reload(auto_reload),
    .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, l;
    int d;
    bit s, p, ar;
    int ec;
    bit et, eb;
  } vec_t;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic m_tick(bit ar);
    if (m_count > 1) begin
      m_count = m_count - 1;
    end else begin
      m_tc = 1;
      if (ar) m_count = m_reload;
      else begin
        m_count = 0;
        m_run   = 0;
        m_done  = 1;
      end
    end
  endtask

  task automatic m_update(bit r, bit l, int d,
                          bit s, bit p, bit ar);
    m_tc = 0;
    if (r) begin
      m_count = 0; m_reload = 0; m_phase = 0;
      m_run = 0; m_done = 0;
    end else if (l) begin
      m_count = d; m_reload = d; m_phase = 0;
      m_run = s; m_done = 0;
    end else if (p) begin
      m_run = 0; m_phase = 0;
    end else if (s && !m_run) begin
      m_phase = 0;
      if (m_done) begin
        m_count = m_reload; m_run = 1; m_done = 0;
      end else if (m_count == 0) begin
        m_done = 1; m_tc = 1;
      end else begin
        m_run = 1;
      end
    end else if (s && TP > 1) begin
      m_phase = 0;
    end else if (m_run) begin
      m_phase = m_phase + 1;
      if (m_phase == TP) begin
        m_phase = 0;
        m_tick(ar);
      end
    end
  endtask

  task automatic step(bit r, bit l, int d,
                      bit s, bit p, bit ar);
    rst = r; load = l; data = d[7:0];
    start = s; stop = p; auto_reload = ar;
    @(posedge clk);
    m_update(r, l, d, s, p, ar);
    #1;
    chk("model_count", int'(count), m_count);
    chk("model_tc", int'(tc), int'(m_tc));
    chk("model_busy", int'(busy), int'(m_run));
  endtask

  task automatic expect3(string n, int c, bit t, bit b);
    chk({n, "_count"}, int'(count), c);
    chk({n, "_tc"}, int'(tc), int'(t));
    chk({n, "_busy"}, int'(busy), int'(b));
  endtask

  task automatic run_until(int target, bit ar);
    int n = 0;
    while (m_count != target && n < 3000) begin
      step(0, 0, 0, 0, 0, ar);
      n++;
    end
    chk("run_until_bound", int'(n < 3000), 1);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1; load = 0; data = 0;
    start = 0; stop = 0; auto_reload = 0;

    tbl = '{
      '{1,0,0,0,0,0, 0,0,0},
      '{1,0,0,0,0,0, 0,0,0},
      '{0,1,5,0,0,0, 5,0,0},
      '{0,0,0,1,0,0, 5,0,1},
      '{0,0,0,0,0,0, 4,0,1},
      '{0,0,0,0,0,0, 3,0,1},
      '{0,0,0,0,0,0, 2,0,1},
      '{0,0,0,0,0,0, 1,0,1},
      '{0,0,0,0,0,0, 0,1,0},
      '{0,0,0,0,0,0, 0,0,0},
      '{0,0,0,0,0,0, 0,0,0},
      '{0,1,3,0,0,1, 3,0,0},
      '{0,0,0,1,0,1, 3,0,1},
      '{0,0,0,0,0,1, 2,0,1},
      '{0,0,0,0,0,1, 1,0,1},
      '{0,0,0,0,0,1, 3,1,1},
      '{0,0,0,0,0,1, 2,0,1},
      '{0,0,0,0,0,1, 1,0,1},
      '{0,0,0,0,0,1, 3,1,1},
      '{0,0,0,0,1,1, 3,0,0},
      '{0,0,0,0,0,1, 3,0,0},
      '{0,0,0,1,0,1, 3,0,1},
      '{0,0,0,0,0,1, 2,0,1},
      '{0,1,0,0,0,0, 0,0,0},
      '{0,0,0,1,0,0, 0,1,0},
      '{0,0,0,0,0,0, 0,0,0},
      '{0,0,0,1,0,0, 0,0,1},
      '{0,0,0,0,0,0, 0,1,0}
    };

`ifndef COUNTER_DOWN_PRESCALE_EN
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].d,
           tbl[i].s, tbl[i].p, tbl[i].ar);
      expect3($sformatf("vec%0d", i),
              tbl[i].ec, tbl[i].et, tbl[i].eb);
    end
`else
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    expect3("reset", 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    expect3("ps_load", 2, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    expect3("ps_start", 2, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    expect3("ps_hold2", 2, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    expect3("ps_one", 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    expect3("ps_hold1", 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    expect3("ps_zero", 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    expect3("ps_after", 0, 0, 0);
`endif

    step(0, 1, 200, 1, 0, 0);
    expect3("pr_load", 200, 0, 1);
    run_until(100, 0);
    step(0, 0, 0, 0, 1, 0);
    expect3("pr_stop", 100, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);
    expect3("pr_held", 100, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    expect3("pr_resume", 100, 0, 1);
    run_until(99, 0);
    expect3("pr_99", 99, 0, 1);

    step(0, 1, 60, 1, 0, 0);
    run_until(40, 0);
    step(0, 1, 50, 0, 0, 0);
    expect3("mid_load", 50, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    run_until(45, 0);
    step(1, 0, 0, 0, 0, 0);
    expect3("mid_rst", 0, 0, 0);

    for (int k = 0; k < 4000; k++) begin
      int  u  = $urandom_range(0, 99);
      bit  r  = (u == 0);
      bit  l  = (u >= 1 && u <= 5);
      bit  p  = (u >= 6 && u <= 9);
      bit  s  = (u >= 10 && u <= 19) || (l && u[0]);
      bit  ar = ($urandom_range(0, 3) != 0);
      int  d  = ($urandom_range(0, 3) == 0) ?
                $urandom_range(0, 255) :
                $urandom_range(0, 6);
      step(r, l, d, s, p, ar);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
